// File: rtl/fetch_decode_buffer.sv
// Instruction-fetch front end: in-order imem requests, response FIFO, immediate-type pre-decode.
// Define FETCH_MISALIGN_CHECK_EN to add the sticky fetch_misalign output for misaligned redirects.
module fetch_decode_buffer #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    input  logic        imem_gnt,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        dec_valid,
    input  logic        dec_ready,
    output logic [31:0] dec_pc,
    output logic [31:0] dec_instr,
    output logic [24:0] imm_inp,
    output logic [1:0]  imm_sel,
`ifdef FETCH_MISALIGN_CHECK_EN
    output logic        imm_used,
    output logic        fetch_misalign
`else
    output logic        imm_used
`endif
);

    localparam int             PTR_W   = $clog2(DEPTH);
    localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(DEPTH);

    logic [31:0]      pc_q, pc_d;
    logic [31:0]      respPc_q, respPc_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] outstanding_q, outstanding_d;
    logic [CNT_W-1:0] drop_q, drop_d;
    logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
    logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
    logic [31:0]      memPc    [DEPTH];
    logic [31:0]      memInstr [DEPTH];

    logic             grant;
    logic             push;
    logic             pop;
    logic             dropResp;
    logic [31:0]      redirectPcAligned;
    logic [CNT_W:0]   inFlight;

    // Buffered plus outstanding never exceeds DEPTH, so every response has a free slot.
    assign inFlight          = {1'b0, count_q} + {1'b0, outstanding_q};
    assign imem_req          = rst_n && !redirect && (inFlight < DEPTH_C);
    assign imem_addr         = pc_q;
    assign grant             = imem_req && imem_gnt;
    assign dropResp          = imem_rvalid && (drop_q != '0);
    assign push              = imem_rvalid && (drop_q == '0) && !redirect;
    assign dec_valid         = (count_q != '0);
    assign pop               = dec_valid && dec_ready && !redirect;
    assign redirectPcAligned = {redirect_pc[31:2], 2'b00};

`ifndef FETCH_MISALIGN_CHECK_EN
    logic unusedRedirectLsb;
    assign unusedRedirectLsb = ^redirect_pc[1:0];
`endif

    // respPc tracks the PC of the oldest response that will actually be enqueued.
    always_comb begin
        pc_d          = pc_q;
        respPc_d      = respPc_q;
        count_d       = count_q;
        outstanding_d = outstanding_q;
        drop_d        = drop_q;
        rdPtr_d       = rdPtr_q;
        wrPtr_d       = wrPtr_q;
        if (redirect) begin
            pc_d          = redirectPcAligned;
            respPc_d      = redirectPcAligned;
            count_d       = '0;
            rdPtr_d       = '0;
            wrPtr_d       = '0;
            outstanding_d = outstanding_q - CNT_W'(imem_rvalid);
            drop_d        = outstanding_q - CNT_W'(imem_rvalid);
        end else begin
            if (grant) begin
                pc_d = pc_q + 32'd4;
            end
            if (push) begin
                respPc_d = respPc_q + 32'd4;
                wrPtr_d  = wrPtr_q + PTR_W'(1);
            end
            if (pop) begin
                rdPtr_d = rdPtr_q + PTR_W'(1);
            end
            if (dropResp) begin
                drop_d = drop_q - CNT_W'(1);
            end
            count_d       = count_q + CNT_W'(push) - CNT_W'(pop);
            outstanding_d = outstanding_q + CNT_W'(grant) - CNT_W'(imem_rvalid);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q          <= RESET_PC;
            respPc_q      <= RESET_PC;
            count_q       <= '0;
            outstanding_q <= '0;
            drop_q        <= '0;
            rdPtr_q       <= '0;
            wrPtr_q       <= '0;
        end else begin
            pc_q          <= pc_d;
            respPc_q      <= respPc_d;
            count_q       <= count_d;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
            rdPtr_q       <= rdPtr_d;
            wrPtr_q       <= wrPtr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            memPc[wrPtr_q]    <= respPc_q;
            memInstr[wrPtr_q] <= imem_rdata;
        end
    end

    assign dec_pc    = dec_valid ? memPc[rdPtr_q]    : '0;
    assign dec_instr = dec_valid ? memInstr[rdPtr_q] : '0;
    assign imm_inp   = dec_instr[31:7];

    always_comb begin
        imm_sel  = 2'd0;
        imm_used = 1'b0;
        case (dec_instr[6:0])
            7'b0000011, 7'b0010011, 7'b1100111: begin
                imm_sel  = 2'd0;
                imm_used = 1'b1;
            end
            7'b0100011: begin
                imm_sel  = 2'd1;
                imm_used = 1'b1;
            end
            7'b1101111: begin
                imm_sel  = 2'd2;
                imm_used = 1'b1;
            end
            7'b0110111, 7'b0010111: begin
                imm_sel  = 2'd3;
                imm_used = 1'b1;
            end
            default: begin
                imm_sel  = 2'd0;
                imm_used = 1'b0;
            end
        endcase
    end

`ifdef FETCH_MISALIGN_CHECK_EN
    logic fetchMisalign_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetchMisalign_q <= 1'b0;
        end else if (redirect && (redirect_pc[1:0] != 2'b00)) begin
            fetchMisalign_q <= 1'b1;
        end
    end

    assign fetch_misalign = fetchMisalign_q;
`endif

endmodule

// File: tb/tb_fetch_decode_buffer.sv
// Randomized scoreboard bench for fetch_decode_buffer: a memory model tags requests with a redirect
// epoch, surviving responses feed an expected-decode queue that an independent monitor checks.
module tb_fetch_decode_buffer;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic        imem_gnt = 1'b0;
    logic [31:0] imem_addr;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        dec_valid;
    logic        dec_ready = 1'b0;
    logic [31:0] dec_pc;
    logic [31:0] dec_instr;
    logic [24:0] imm_inp;
    logic [1:0]  imm_sel;
    logic        imm_used;

    always #5 clk = ~clk;

    fetch_decode_buffer #(
        .DEPTH(DEPTH),
        .RESET_PC(RESET_PC),
        .CNT_W(3)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .imem_req(imem_req),
        .imem_gnt(imem_gnt),
        .imem_addr(imem_addr),
        .imem_rvalid(imem_rvalid),
        .imem_rdata(imem_rdata),
        .redirect(redirect),
        .redirect_pc(redirect_pc),
        .dec_valid(dec_valid),
        .dec_ready(dec_ready),
        .dec_pc(dec_pc),
        .dec_instr(dec_instr),
        .imm_inp(imm_inp),
        .imm_sel(imm_sel),
        .imm_used(imm_used)
    );

    typedef struct {
        logic [31:0] addr;
        int          epoch;
    } reqT;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } entT;

    reqT         pending[$];
    entT         sb[$];
    logic [31:0] memWords[64];
    logic [31:0] nextAddr = RESET_PC;
    int          epoch = 0;
    int          fifoNow = 0;
    int          checks = 0;
    int          errors = 0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Returns {used, sel} from the opcode table of the immediate extender.
    function automatic logic [2:0] expImm(input logic [31:0] w);
        case (w[6:0])
            7'b0000011, 7'b0010011, 7'b1100111: return 3'b100;
            7'b0100011:                         return 3'b101;
            7'b1101111:                         return 3'b110;
            7'b0110111, 7'b0010111:             return 3'b111;
            default:                            return 3'b000;
        endcase
    endfunction

    function automatic logic [31:0] wordAt(input logic [31:0] a);
        return memWords[a[7:2]];
    endfunction

    function automatic logic [6:0] randomOpcode();
        case ($urandom_range(8))
            0:       return 7'b0000011;
            1:       return 7'b0010011;
            2:       return 7'b1100111;
            3:       return 7'b0100011;
            4:       return 7'b1101111;
            5:       return 7'b0110111;
            6:       return 7'b0010111;
            7:       return 7'b0110011;
            default: return 7'b1100011;
        endcase
    endfunction

    function automatic logic [31:0] pickTarget();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(3))
            0:       return 32'h0000_0100;
            1:       return {24'h0, r[7:0]};
            2:       return 32'hFFFF_FFF8;
            default: return r;
        endcase
    endfunction

    // Decode-side monitor: compares the FIFO head against the expected queue and retires it.
    always @(negedge clk) begin
        if (rst_n) begin
            fifoNow = sb.size();
            checkOutput("dec_valid", dec_valid, sb.size() != 0);
            if (sb.size() != 0) begin
                checkOutput("dec_pc", dec_pc, sb[0].pc);
                checkOutput("dec_instr", dec_instr, sb[0].instr);
                checkOutput("imm_inp", imm_inp, sb[0].instr[31:7]);
                checkOutput("imm_used_sel", {imm_used, imm_sel}, expImm(sb[0].instr));
            end else begin
                checkOutput("empty_dec_pc", dec_pc, 32'h0);
                checkOutput("empty_dec_instr", dec_instr, 32'h0);
                checkOutput("empty_imm_used", imm_used, 1'b0);
            end
            if (redirect) begin
                sb.delete();
            end else if (sb.size() != 0 && dec_ready) begin
                void'(sb.pop_front());
            end
        end
    end

    // Memory-side bookkeeping for the cycle just driven; runs after the monitor has sampled.
    task automatic bookkeep();
        logic expReq;
        reqT  r;
        expReq = !redirect && ((pending.size() + fifoNow) < DEPTH);
        checkOutput("imem_req", imem_req, expReq);
        if (expReq) begin
            checkOutput("imem_addr", imem_addr, nextAddr);
        end
        if (imem_rvalid) begin
            r = pending.pop_front();
            if (!redirect && r.epoch == epoch) begin
                sb.push_back('{pc: r.addr, instr: wordAt(r.addr)});
            end
        end
        if (expReq && imem_gnt) begin
            pending.push_back('{addr: nextAddr, epoch: epoch});
            nextAddr = nextAddr + 32'd4;
        end
        if (redirect) begin
            epoch++;
            nextAddr = {redirect_pc[31:2], 2'b00};
        end
    endtask

    task automatic driveCycle(input bit g, input bit v, input bit rdy, input bit redir, input logic [31:0] tgt);
        logic [31:0] a;
        @(posedge clk);
        #1;
        imem_gnt = g;
        if (v && pending.size() != 0) begin
            a           = pending[0].addr;
            imem_rvalid = 1'b1;
            imem_rdata  = wordAt(a);
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = $urandom;
        end
        dec_ready   = rdy;
        redirect    = redir;
        redirect_pc = tgt;
        @(negedge clk);
        #1;
        bookkeep();
    endtask

    task automatic applyStimulus(input int n, input int pG, input int pV, input int pR, input int pD);
        repeat (n) begin
            driveCycle($urandom_range(99) < pG, $urandom_range(99) < pV,
                       $urandom_range(99) < pR, $urandom_range(99) < pD, pickTarget());
        end
    endtask

    initial begin
        logic [31:0] w;
        for (int i = 0; i < 64; i++) begin
            w        = $urandom;
            w[6:0]   = randomOpcode();
            memWords[i] = w;
        end
        memWords[0] = 32'h00A0_0093;
        memWords[1] = 32'h0000_006F;
        memWords[2] = 32'h0020_8033;

        repeat (2) @(negedge clk);
        checkOutput("reset_imem_req", imem_req, 1'b0);
        checkOutput("reset_dec_valid", dec_valid, 1'b0);
        checkOutput("reset_dec_pc", dec_pc, 32'h0);
        checkOutput("reset_dec_instr", dec_instr, 32'h0);
        checkOutput("reset_imm_inp", imm_inp, 25'h0);
        checkOutput("reset_imm_sel", imm_sel, 2'd0);
        checkOutput("reset_imm_used", imm_used, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        applyStimulus(30, 100, 100, 100, 0);
        applyStimulus(10, 100, 100, 0, 0);
        applyStimulus(20, 100, 100, 100, 0);

        driveCycle(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
        driveCycle(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
        driveCycle(1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0100);
        applyStimulus(20, 100, 100, 100, 0);

        driveCycle(1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0040);
        applyStimulus(10, 100, 100, 100, 0);

        driveCycle(1'b1, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFF8);
        applyStimulus(15, 100, 100, 100, 0);

        applyStimulus(3000, 70, 50, 70, 4);
        applyStimulus(50, 100, 100, 100, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
